// File: rtl/rr_grant_encoder_if.sv
// Request/grant bundle between requesters and rr_grant_encoder.
// master drives requests and done; slave (the arbiter) drives the grant.
interface rr_grant_encoder_if #(
  parameter int NI = 3
);
  logic [2**NI-1:0] req;
  logic             done;
  logic             gnt_valid;
  logic [NI-1:0]    gnt_idx;
  logic             timeout;

  modport master (
    output req,
    output done,
    input  gnt_valid,
    input  gnt_idx,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt_valid,
    output gnt_idx,
    output timeout
  );
endinterface

// File: rtl/rr_grant_encoder.sv
// Locking round-robin arbiter over 2**NI requesters with a registered binary grant index.
// Define RR_TIMEOUT_EN to force-release grants held for MAX_HOLD cycles.
module rr_grant_encoder #(
  parameter int NI       = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  rr_grant_encoder_if.slave bus
);

  localparam int N = 2**NI;

  typedef enum logic {IDLE, GRANTED} state_e;

  state_e        state_q, state_d;
  logic [NI-1:0] ptr_q, ptr_d;
  logic [NI-1:0] gntIdx_q, gntIdx_d;
  logic [NI-1:0] winner, cand;
  logic          found;
  logic          expire;

  if (MAX_HOLD < 1 || MAX_HOLD > 65535) begin : gBadMaxHold
    $error("rr_grant_encoder: MAX_HOLD must lie in 1..65535");
  end

  // Single-pass combinational scan starting at ptr; the first hit wins.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    cand   = ptr_q;
    for (int k = 0; k < N; k++) begin
      cand = ptr_q + NI'(k);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

`ifdef RR_TIMEOUT_EN
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [CW-1:0] holdCnt_q, holdCnt_d;
  logic          timeout_q, timeout_d;

  assign expire = (state_q == GRANTED) && (holdCnt_q == CW'(MAX_HOLD - 1));

  // Counter restarts from zero on every entry to GRANTED; done beats expiry.
  always_comb begin
    holdCnt_d = '0;
    timeout_d = 1'b0;
    if (state_q == GRANTED) begin
      holdCnt_d = holdCnt_q + CW'(1);
      timeout_d = expire && !bus.done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      holdCnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      holdCnt_q <= holdCnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gntIdx_d = gntIdx_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gntIdx_d = winner;
          state_d  = GRANTED;
        end
      end
      GRANTED: begin
        // Requests are ignored while locked; release rotates priority past the owner.
        if (bus.done || expire) begin
          ptr_d   = gntIdx_q + NI'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gntIdx_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gntIdx_q <= gntIdx_d;
    end
  end

  assign bus.gnt_valid = (state_q == GRANTED);
  assign bus.gnt_idx   = gntIdx_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed scoreboard bench for rr_grant_encoder; each step queues the outputs
// expected after the next rising edge, then pops and compares them 1 ns past it.
module tb_rr_grant_encoder;

  localparam int NI = 3;

  typedef struct {
    string         tag;
    logic          valid;
    logic [NI-1:0] idx;
    logic          to;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sbQ[$];
  int   vecCount;
  int   missCount;

  rr_grant_encoder_if #(.NI(NI)) bus ();

  rr_grant_encoder #(
    .NI       (NI),
    .MAX_HOLD (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput();
    exp_t            e;
    logic [NI+1:0]   obs;
    logic [NI+1:0]   want;
    vecCount++;
    assert (sbQ.size() != 0) else begin
      missCount++;
      $error("[TB] FAIL scoreboardEmpty: observed 0 queued entries, expected at least 1");
      return;
    end
    e    = sbQ.pop_front();
    obs  = {bus.gnt_valid, bus.gnt_idx, bus.timeout};
    want = {e.valid, e.idx, e.to};
    assert (obs === want) else begin
      missCount++;
      $error("[TB] FAIL %s: observed valid=%b idx=%0d timeout=%b, expected valid=%b idx=%0d timeout=%b",
             e.tag, bus.gnt_valid, bus.gnt_idx, bus.timeout, e.valid, e.idx, e.to);
    end
  endtask

  task automatic applyStimulus(input logic rstV, input logic [7:0] reqV, input logic doneV,
                               input logic expValid, input logic [NI-1:0] expIdx,
                               input logic expTo, input string tag);
    exp_t e;
    rst      = rstV;
    bus.req  = reqV;
    bus.done = doneV;
    e.tag    = tag;
    e.valid  = expValid;
    e.idx    = expIdx;
    e.to     = expTo;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    vecCount  = 0;
    missCount = 0;
    rst       = 1'b1;
    bus.req   = '0;
    bus.done  = 1'b0;
    $display("[TB] rr_grant_encoder directed run");

    applyStimulus(1, 8'hFF, 0, 0, 0, 0, "reset0");
    applyStimulus(1, 8'hFF, 0, 0, 0, 0, "reset1");
    applyStimulus(0, 8'hFF, 0, 1, 0, 0, "firstGrant");
    applyStimulus(0, 8'hFF, 1, 0, 0, 0, "release0");

    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 8'hFF, 0, 1, NI'(i % 8), 0, "fairGrant");
      applyStimulus(0, 8'hFF, 1, 0, NI'(i % 8), 0, "fairBubble");
    end

    applyStimulus(0, 8'h00, 1, 0, 0, 0, "doneInIdle");
    applyStimulus(0, 8'h00, 0, 0, 0, 0, "idleHold");

    applyStimulus(0, 8'h04, 0, 1, 2, 0, "single");
    applyStimulus(0, 8'h00, 0, 1, 2, 0, "lock0");
    applyStimulus(0, 8'h00, 0, 1, 2, 0, "lock1");
    applyStimulus(0, 8'h00, 1, 0, 2, 0, "singleRelease");

    applyStimulus(0, 8'h40, 0, 1, 6, 0, "grant6");
    applyStimulus(0, 8'h05, 1, 0, 6, 0, "doneWithReq");
    applyStimulus(0, 8'h05, 0, 1, 0, 0, "wrapTo0");
    applyStimulus(0, 8'h05, 1, 0, 0, 0, "release0b");
    applyStimulus(0, 8'h05, 0, 1, 2, 0, "skipTo2");
    applyStimulus(0, 8'h05, 1, 0, 2, 0, "release2");

    applyStimulus(0, 8'hFF, 0, 1, 3, 0, "grant3");
    applyStimulus(0, 8'h00, 0, 1, 3, 0, "lockNoDone0");
    applyStimulus(0, 8'h00, 0, 1, 3, 0, "lockNoDone1");
    applyStimulus(1, 8'hFF, 0, 0, 0, 0, "resetMidGrant");
    applyStimulus(0, 8'h82, 0, 1, 1, 0, "ptrCleared");
    applyStimulus(0, 8'h82, 1, 0, 1, 0, "release1");

    applyStimulus(0, 8'h03, 0, 1, 0, 0, "loserFirst");
    applyStimulus(0, 8'h03, 1, 0, 0, 0, "release0c");
    applyStimulus(0, 8'h03, 0, 1, 1, 0, "rotateBack");
    applyStimulus(0, 8'h00, 1, 0, 1, 0, "release1b");

`ifdef RR_TIMEOUT_EN
    applyStimulus(0, 8'h20, 0, 1, 5, 0, "toGrant5");
    for (int k = 0; k < 3; k++)
      applyStimulus(0, 8'h00, 0, 1, 5, 0, "toHold");
    applyStimulus(0, 8'hFF, 0, 0, 5, 1, "toExpire");
    applyStimulus(0, 8'hFF, 0, 1, 6, 0, "toNextGrant6");
    for (int k = 0; k < 3; k++)
      applyStimulus(0, 8'h00, 0, 1, 6, 0, "coHold");
    applyStimulus(0, 8'h00, 1, 0, 6, 0, "doneAtExpiry");
    applyStimulus(0, 8'h00, 0, 0, 6, 0, "noLateTimeout");
`else
    applyStimulus(0, 8'h20, 0, 1, 5, 0, "holdGrant5");
    for (int k = 0; k < 6; k++)
      applyStimulus(0, 8'h00, 0, 1, 5, 0, "holdForever");
    applyStimulus(0, 8'h00, 1, 0, 5, 0, "holdRelease");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
